// File: rtl/rc4_pkg.sv
// Shared RC4 types for the init, key-schedule, decrypt and checker loops.
// Holds the decrypt FSM state encoding, byte/index types and message length.
package rc4_pkg;

   localparam int MSG_LEN_DEF = 32;

   typedef logic [7:0] byte_t;
   typedef logic [5:0] idx_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR_I,
      ST_WAIT_I,
      ST_GET_I,
      ST_WAIT_J,
      ST_GET_J,
      ST_SWAP_I,
      ST_ADDR_F,
      ST_WAIT_F,
      ST_GET_F,
      ST_WAIT_ACK,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rc4_decrypt_loop_if.sv
// Handshake between the decrypt loop and the downstream key checker.
// master: char_out/new_char/char_count/done out, start_over/compared_char in.
interface rc4_chk_if;
   import rc4_pkg::*;

   logic  start_over;
   logic  compared_char;
   byte_t char_out;
   logic  new_char;
   idx_t  char_count;
   logic  done;

   modport master (
      input  start_over,
      input  compared_char,
      output char_out,
      output new_char,
      output char_count,
      output done
   );

   modport slave (
      output start_over,
      output compared_char,
      input  char_out,
      input  new_char,
      input  char_count,
      input  done
   );

endinterface

// File: rtl/rc4_decrypt_loop.sv
// RC4 PRGA/decrypt loop: one keystream byte per ciphertext byte, XORed
// into the plaintext RAM and offered to the checker via the chk handshake.
// Ports: clk, resetm (async, active-low), start pulse, chk (checker
// handshake), S-RAM bus (s_*), ciphertext ROM (enc_*), plaintext RAM (dec_*).
module rc4_decrypt_loop
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEF
) (
   input  logic       clk,
   input  logic       resetm,
   input  logic       start,
   rc4_chk_if.master  chk,
   output byte_t      s_addr,
   output byte_t      s_wrdata,
   output logic       s_wren,
   input  byte_t      s_rddata,
   output logic [4:0] enc_addr,
   input  byte_t      enc_rddata,
   output logic [4:0] dec_addr,
   output byte_t      dec_wrdata,
   output logic       dec_wren
);

   localparam idx_t LAST = idx_t'(MSG_LEN - 1);
   localparam idx_t FIN  = idx_t'(MSG_LEN + 1);

   state_t state_q, state_d;

   byte_t i_q, i_d;
   byte_t j_q, j_d;
   byte_t si_q, si_d;
   byte_t sj_q, sj_d;
   idx_t  k_q, k_d;

   byte_t      s_addr_q, s_addr_d;
   byte_t      s_wrdata_q, s_wrdata_d;
   logic       s_wren_q, s_wren_d;
   logic [4:0] enc_addr_q, enc_addr_d;
   logic [4:0] dec_addr_q, dec_addr_d;
   byte_t      dec_wrdata_q, dec_wrdata_d;
   logic       dec_wren_q, dec_wren_d;
   byte_t      char_q, char_d;
   logic       nc_q, nc_d;
   idx_t       cnt_q, cnt_d;
   logic       done_q, done_d;

   logic  abort;
   logic  ack;
   logic  last;
   byte_t f;

   assign abort = chk.start_over;
   assign ack   = chk.compared_char;
   assign last  = (k_q == LAST);
   assign f     = s_rddata ^ enc_rddata;

   always_ff @(posedge clk or negedge resetm) begin
      if (!resetm) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_ADDR_I;
            ST_ADDR_I:   state_d = ST_WAIT_I;
            ST_WAIT_I:   state_d = ST_GET_I;
            ST_GET_I:    state_d = ST_WAIT_J;
            ST_WAIT_J:   state_d = ST_GET_J;
            ST_GET_J:    state_d = ST_SWAP_I;
            ST_SWAP_I:   state_d = ST_ADDR_F;
            ST_ADDR_F:   state_d = ST_WAIT_F;
            ST_WAIT_F:   state_d = ST_GET_F;
            ST_GET_F:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack) state_d = last ? ST_DONE : ST_ADDR_I;
            ST_DONE:     state_d = ST_DONE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      i_d          = i_q;
      j_d          = j_q;
      si_d         = si_q;
      sj_d         = sj_q;
      k_d          = k_q;
      s_addr_d     = s_addr_q;
      s_wrdata_d   = s_wrdata_q;
      s_wren_d     = s_wren_q;
      enc_addr_d   = enc_addr_q;
      dec_addr_d   = dec_addr_q;
      dec_wrdata_d = dec_wrdata_q;
      dec_wren_d   = dec_wren_q;
      char_d       = char_q;
      nc_d         = nc_q;
      cnt_d        = cnt_q;
      done_d       = done_q;
      unique case (state_q)
         ST_ADDR_I: begin
            i_d        = i_q + 8'd1;
            s_addr_d   = i_q + 8'd1;
            enc_addr_d = k_q[4:0];
         end
         ST_GET_I: begin
            si_d     = s_rddata;
            j_d      = j_q + s_rddata;
            s_addr_d = j_q + s_rddata;
         end
         // i==j writes the same value twice to one address: S unchanged
         ST_GET_J: begin
            sj_d       = s_rddata;
            s_addr_d   = j_q;
            s_wrdata_d = si_q;
            s_wren_d   = 1'b1;
         end
         ST_SWAP_I: begin
            s_addr_d   = i_q;
            s_wrdata_d = sj_q;
            s_wren_d   = 1'b1;
         end
         ST_ADDR_F: begin
            s_wren_d = 1'b0;
            s_addr_d = si_q + sj_q;
         end
         ST_GET_F: begin
            char_d       = f;
            dec_wrdata_d = f;
            dec_addr_d   = k_q[4:0];
            dec_wren_d   = 1'b1;
            nc_d         = 1'b1;
         end
         ST_WAIT_ACK: begin
            nc_d       = 1'b0;
            dec_wren_d = 1'b0;
            if (ack && !last) begin
               k_d   = k_q + 6'd1;
               cnt_d = k_q + 6'd1;
            end
         end
         ST_DONE: begin
            done_d = 1'b1;
            cnt_d  = FIN;
         end
         default: ;
      endcase
      // abort drops any pending S write and rewinds the indices
      if (abort) begin
         i_d        = '0;
         j_d        = '0;
         k_d        = '0;
         s_wren_d   = 1'b0;
         dec_wren_d = 1'b0;
         nc_d       = 1'b0;
         done_d     = 1'b0;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge resetm) begin
      if (!resetm) begin
         i_q          <= '0;
         j_q          <= '0;
         si_q         <= '0;
         sj_q         <= '0;
         k_q          <= '0;
         s_addr_q     <= '0;
         s_wrdata_q   <= '0;
         s_wren_q     <= 1'b0;
         enc_addr_q   <= '0;
         dec_addr_q   <= '0;
         dec_wrdata_q <= '0;
         dec_wren_q   <= 1'b0;
         char_q       <= '0;
         nc_q         <= 1'b0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         i_q          <= i_d;
         j_q          <= j_d;
         si_q         <= si_d;
         sj_q         <= sj_d;
         k_q          <= k_d;
         s_addr_q     <= s_addr_d;
         s_wrdata_q   <= s_wrdata_d;
         s_wren_q     <= s_wren_d;
         enc_addr_q   <= enc_addr_d;
         dec_addr_q   <= dec_addr_d;
         dec_wrdata_q <= dec_wrdata_d;
         dec_wren_q   <= dec_wren_d;
         char_q       <= char_d;
         nc_q         <= nc_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
      end
   end

   assign s_addr         = s_addr_q;
   assign s_wrdata       = s_wrdata_q;
   assign s_wren         = s_wren_q;
   assign enc_addr       = enc_addr_q;
   assign dec_addr       = dec_addr_q;
   assign dec_wrdata     = dec_wrdata_q;
   assign dec_wren       = dec_wren_q;
   assign chk.char_out   = char_q;
   assign chk.new_char   = nc_q;
   assign chk.char_count = cnt_q;
   assign chk.done       = done_q;

endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// Self-checking bench for rc4_decrypt_loop: memory models, RC4 reference,
// per-char compare process and directed/random scenarios.
module tb_rc4_decrypt_loop;
   import rc4_pkg::*;

   localparam int N = MSG_LEN_DEF;

   logic clk = 1'b0;
   logic resetm = 1'b0;
   logic start = 1'b0;

   byte_t      s_addr, s_wrdata, s_rddata;
   byte_t      enc_rddata, dec_wrdata;
   logic       s_wren, dec_wren;
   logic [4:0] enc_addr, dec_addr;

   rc4_chk_if chk();

   rc4_decrypt_loop #(.MSG_LEN(N)) dut (
      .clk        (clk),
      .resetm     (resetm),
      .start      (start),
      .chk        (chk),
      .s_addr     (s_addr),
      .s_wrdata   (s_wrdata),
      .s_wren     (s_wren),
      .s_rddata   (s_rddata),
      .enc_addr   (enc_addr),
      .enc_rddata (enc_rddata),
      .dec_addr   (dec_addr),
      .dec_wrdata (dec_wrdata),
      .dec_wren   (dec_wren)
   );

   always #5 clk = ~clk;

   byte_t s_mem [256];
   byte_t s_init [256];
   byte_t enc_mem [32];
   byte_t dec_mem [32];
   byte_t exp_c [32];

   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_idx = 0;
   int   s_wr_cnt = 0;
   int   dec_wr_cnt = 0;
   int   nc_cnt = 0;
   logic prev_nc = 1'b0;

   always @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      s_rddata   <= s_mem[s_addr];
      enc_rddata <= enc_mem[enc_addr];
      if (dec_wren) dec_mem[dec_addr] <= dec_wrdata;
   end

   task automatic check(string nm, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Textbook RC4 PRGA over a private copy of the initial S-box
   task automatic build_model();
      byte_t s [256];
      byte_t i, j, t, fi;
      for (int a = 0; a < 256; a++) s[a] = s_init[a];
      i = 0;
      j = 0;
      for (int k = 0; k < N; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i];
         s[i] = s[j];
         s[j] = t;
         fi = s[i] + s[j];
         exp_c[k] = s[fi] ^ enc_mem[k];
      end
   endtask

   task automatic load(bit ident, bit zero_enc);
      byte_t t;
      int r;
      for (int a = 0; a < 256; a++) s_init[a] = byte_t'(a);
      if (!ident) begin
         for (int a = 255; a > 0; a--) begin
            r = $urandom_range(a, 0);
            t = s_init[a];
            s_init[a] = s_init[r];
            s_init[r] = t;
         end
      end
      for (int a = 0; a < 256; a++) s_mem[a] = s_init[a];
      for (int a = 0; a < 32; a++) begin
         enc_mem[a] = zero_enc ? 8'h00 : byte_t'($urandom_range(255, 0));
         dec_mem[a] = 8'h00;
      end
      build_model();
   endtask

   always @(negedge clk) begin
      if (resetm && s_wren) s_wr_cnt++;
      if (resetm && dec_wren) dec_wr_cnt++;
      if (resetm && chk.new_char) begin
         nc_cnt++;
         check("nc_single", prev_nc, 0);
         if (exp_idx < N) begin
            check("char_out", chk.char_out, exp_c[exp_idx]);
            check("char_count", chk.char_count, exp_idx);
            check("dec_addr", dec_addr, exp_idx);
            check("dec_wrdata", dec_wrdata, exp_c[exp_idx]);
            check("dec_wren", dec_wren, 1);
         end else begin
            check("char_idx", exp_idx, N - 1);
         end
         exp_idx++;
      end
      prev_nc = chk.new_char;
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      s_wr_cnt = 0;
      dec_wr_cnt = 0;
      nc_cnt = 0;
   endtask

   task automatic pulse_start();
      exp_idx = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ack();
      chk.compared_char = 1'b1;
      tick();
      chk.compared_char = 1'b0;
   endtask

   task automatic wait_nc(output int edges);
      edges = 0;
      forever begin
         @(posedge clk);
         edges++;
         #1;
         if (chk.new_char) break;
         if (edges >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_nc: timeout after %0d edges", edges);
            break;
         end
      end
   endtask

   task automatic abort();
      chk.start_over = 1'b1;
      tick();
      chk.start_over = 1'b0;
   endtask

   task automatic run_full(bit ident);
      int e;
      load(ident, 1'b0);
      clr();
      pulse_start();
      for (int c = 0; c < N; c++) begin
         wait_nc(e);
         check("lat", e, 9);
         tick($urandom_range(3, 0));
         ack();
      end
      tick(2);
      check("done", chk.done, 1);
      check("cnt_fin", chk.char_count, N + 1);
      check("dec_cnt", dec_wr_cnt, N);
      check("nc_cnt", nc_cnt, N);
      for (int k = 0; k < N; k++) check("dec_mem", dec_mem[k], exp_c[k]);
      tick(10);
      check("done_hold", chk.done, 1);
      check("cnt_hold", chk.char_count, N + 1);
      abort();
      check("done_clr", chk.done, 0);
      check("cnt_clr", chk.char_count, 0);
   endtask

   initial begin
      int e;
      chk.start_over = 1'b0;
      chk.compared_char = 1'b0;
      load(1'b1, 1'b1);
      tick(3);
      resetm = 1'b1;
      tick(2);

      check("rst_s_addr", s_addr, 0);
      check("rst_s_wren", s_wren, 0);
      check("rst_dec_wren", dec_wren, 0);
      check("rst_nc", chk.new_char, 0);
      check("rst_cnt", chk.char_count, 0);
      check("rst_done", chk.done, 0);
      check("rst_char", chk.char_out, 0);

      // identity S, zero ciphertext: keystream 02, 05
      pulse_start();
      wait_nc(e);
      check("lat_start", e, 9);
      check("t2_c0", chk.char_out, 8'h02);
      ack();
      wait_nc(e);
      check("lat_ack", e, 9);
      check("t2_c1", chk.char_out, 8'h05);

      // checker stalls for 100 cycles
      tick();
      check("t3_nc_low", chk.new_char, 0);
      clr();
      tick(100);
      check("t3_nc", nc_cnt, 0);
      check("t3_swr", s_wr_cnt, 0);
      check("t3_dwr", dec_wr_cnt, 0);
      check("t3_char", chk.char_out, 8'h05);
      check("t3_cnt", chk.char_count, 1);

      // reset mid-run while an S write is pending
      ack();
      tick(5);
      resetm = 1'b0;
      #1;
      check("ar_s_wren", s_wren, 0);
      check("ar_s_addr", s_addr, 0);
      check("ar_char", chk.char_out, 0);
      check("ar_cnt", chk.char_count, 0);
      check("ar_enc", enc_addr, 0);
      check("ar_dwd", dec_wrdata, 0);
      tick(2);
      resetm = 1'b1;
      clr();
      tick(20);
      check("ar_swr", s_wr_cnt, 0);
      check("ar_dwr", dec_wr_cnt, 0);
      check("ar_nc", nc_cnt, 0);

      // abort in WAIT_J
      load(1'b1, 1'b1);
      pulse_start();
      tick(3);
      abort();
      check("t4_s_wren", s_wren, 0);
      check("t4_cnt", chk.char_count, 0);
      check("t4_nc", chk.new_char, 0);
      clr();
      tick(20);
      check("t4_swr", s_wr_cnt, 0);
      check("t4_nc_cnt", nc_cnt, 0);
      load(1'b1, 1'b1);
      pulse_start();
      wait_nc(e);
      check("t4_lat", e, 9);
      check("t4_c0", chk.char_out, 8'h02);

      // abort and ack together in WAIT_ACK
      chk.start_over = 1'b1;
      chk.compared_char = 1'b1;
      tick();
      chk.start_over = 1'b0;
      chk.compared_char = 1'b0;
      check("t6_cnt", chk.char_count, 0);
      check("t6_nc", chk.new_char, 0);
      clr();
      tick(20);
      check("t6_nc_cnt", nc_cnt, 0);
      check("t6_dwr", dec_wr_cnt, 0);
      load(1'b1, 1'b1);
      pulse_start();
      wait_nc(e);
      check("t6_k0", chk.char_count, 0);
      check("t6_c0", chk.char_out, 8'h02);
      abort();

      // full messages, random keys and ciphertext
      run_full(1'b0);
      run_full(1'b0);
      run_full(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
